d_mem_store_buffer: RTL
=======================

Name: d_mem_store_buffer

Overview:
- Sits between the core's data-memory port and data RAM.
- Absorbs core stores into a small FIFO and drains them to RAM over a valid/ready write channel. This decouples the core from RAM write wait-states.
- Serves core loads with store-to-load forwarding from buffered entries; otherwise passes the load through to RAM's combinational read port.
- Raises a stall when a store arrives while the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, >= 2.
- PTR_W, 2, log2(DEPTH); sizes the read/write pointers.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d_mem_w_addr  input  32  core byte address, shared by loads and stores; bits [1:0] ignored (word access).
- d_mem_w_data  input  32  core store data.
- d_mem_we  input  1  core store request.
- d_mem_oe  input  1  core load request.
- d_mem_r_data  output  32  load data to core (combinational).
- d_mem_stall  output  1  core must hold its store and retry (combinational).
- mem_w_valid  output  1  head entry valid toward RAM.
- mem_w_ready  input  1  RAM accepts the head write this cycle.
- mem_w_addr  output  32  head entry address; bits [1:0] = 0.
- mem_w_data  output  32  head entry data.
- mem_r_addr  output  32  RAM read address = {d_mem_w_addr[31:2], 2'b00}.
- mem_r_data  input  32  RAM combinational read data.
- buf_empty  output  1  count == 0; used by the core/debug to fence.

Behaviour:
- State:
  - DEPTH entries of {addr[31:2], data[31:0]}.
  - wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH).
  - count (PTR_W+1 bits, range 0..DEPTH).
- Reset (rst high at posedge):
  - count=0, wr_ptr=0, rd_ptr=0.
  - Outputs: mem_w_valid=0, buf_empty=1, d_mem_stall=0.
  - Entry contents don't care.
  - Reset mid-drain discards all buffered stores; no RAM write issues after reset, even if mem_w_ready is high.
- Push: push = d_mem_we && (count != DEPTH). Writes entry[wr_ptr] at posedge, then wr_ptr++.
- Stall: d_mem_stall = d_mem_we && (count == DEPTH), combinational.
  - The push check uses count only. A pop in the same cycle does not free a slot for a push until the next cycle.
  - The core holds addr/data/we while stalled.
- Pop / drain:
  - mem_w_valid = (count != 0).
  - mem_w_addr/mem_w_data = entry[rd_ptr]; held stable while valid && !ready.
  - Pop = mem_w_valid && mem_w_ready; rd_ptr++ at posedge.
  - Stores reach RAM strictly in program order, one per accepted handshake.
- Count update: push only +1; pop only -1; push and pop together leaves count unchanged (possible only when 0 < count < DEPTH).
- Latency:
  - A store pushed at edge N appears on mem_w_* in cycle N+1 at the earliest. There is no bypass from d_mem_we straight to mem_w_valid.
- Load forwarding (combinational):
  - When d_mem_oe is high, compare d_mem_w_addr[31:2] against every valid entry. Valid entries are the count entries starting at rd_ptr, including the head being drained this cycle.
  - On a hit, d_mem_r_data = data of the youngest matching entry (closest to wr_ptr).
  - On a miss, d_mem_r_data = mem_r_data.
  - A store presented in the same cycle is never forwarded to a same-cycle load.
  - If d_mem_oe is low, d_mem_r_data = mem_r_data.
- Simultaneous d_mem_we and d_mem_oe is outside the core contract. Required behaviour: the store proceeds per push/stall rules and the load sees only previously buffered entries.
- Wrap-around: pointers wrap DEPTH-1 -> 0. Forwarding age ordering must be correct across the wrap.
- mem_r_addr is combinational from d_mem_w_addr; it is independent of oe and of buffer state.

Test Plan:
- Reset, then one store: addr 0x10, data 0xA5 with mem_w_ready=1 -> buf_empty drops the cycle after the push; mem_w_valid=1 with mem_w_addr=0x10, mem_w_data=0xA5 for exactly one cycle; buf_empty returns to 1.
- Backpressure and stall: mem_w_ready=0; stores to 0x0, 0x4, 0x8, 0xC, then 0x10 -> d_mem_stall=0 for the first four and 1 for the fifth. Raising mem_w_ready drains 0x0 first; the held 0x10 store is accepted the cycle after count drops to 3.
- Forwarding youngest-wins: mem_w_ready=0; store 0x20<-1, then 0x24<-2, then 0x20<-3; load 0x20 -> d_mem_r_data=3. Load 0x24 -> 2. Load 0x28 with mem_r_data=0x77 -> 0x77.
- Forward during drain: single entry 0x30<-9, load 0x30 in the same cycle as the pop handshake (mem_r_data=0) -> d_mem_r_data=9. The next cycle's load 0x30 returns mem_r_data.
- Wrap: 10 stores with ready toggling 1/0 each cycle -> RAM receives all 10 in order with correct data. A load of the 10th address after the 9th pop returns the 10th store's data across the pointer wrap.
- Reset mid-operation: 3 entries pending with mem_w_ready=0, assert rst one cycle -> mem_w_valid=0 and buf_empty=1 next cycle. Subsequently asserting mem_w_ready produces no RAM writes.

Source files
------------

// File: rtl/d_mem_store_buffer.sv
// Store buffer between the core data port and data RAM: a small FIFO of
// word stores drained over valid/ready, with store-to-load forwarding.
module d_mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_mem_w_addr,
    input  logic [31:0] d_mem_w_data,
    input  logic        d_mem_we,
    input  logic        d_mem_oe,
    output logic [31:0] d_mem_r_data,
    output logic        d_mem_stall,
    output logic        mem_w_valid,
    input  logic        mem_w_ready,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data,
    output logic        buf_empty
);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic             unused_addr_lsbs;

    assign full        = (count_q == (PTR_W+1)'(DEPTH));
    assign push        = d_mem_we && !full;
    assign d_mem_stall = d_mem_we && full;
    assign mem_w_valid = (count_q != '0);
    assign pop         = mem_w_valid && mem_w_ready;
    assign buf_empty   = (count_q == '0);
    assign mem_w_addr  = {addr_q[rd_ptr_q], 2'b00};
    assign mem_w_data  = data_q[rd_ptr_q];
    assign mem_r_addr  = {d_mem_w_addr[31:2], 2'b00};
    assign unused_addr_lsbs = ^d_mem_w_addr[1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= d_mem_w_addr[31:2];
            data_q[wr_ptr_q] <= d_mem_w_data;
        end
    end

    // Walk entries oldest to youngest from rd_ptr so the last match (youngest) wins across the wrap.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (addr_q[idx] == d_mem_w_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign d_mem_r_data = (d_mem_oe && fwd_hit) ? fwd_data : mem_r_data;

endmodule
